// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: program counter, internal instruction memory and
// the IF/ID pipeline register of the 5-stage MIPS pipeline. Obeys the hazard
// unit's PC/IF-ID enables, takes branch/jump redirects from EX and freezes
// fetch once a HALT instruction commits from IF/ID.
// Optional single-step debug ports: define IF_DEBUG_STEP_EN.
module instruction_fetch_stage #(
  parameter int unsigned         PC_WIDTH   = 32,
  parameter int unsigned         IMEM_DEPTH = 256,
  parameter int unsigned         IMEM_AW    = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                CLK,
  input  logic                RESET,
`ifdef IF_DEBUG_STEP_EN
  input  logic                I_IF_STEP_MODE,
  input  logic                I_IF_STEP,
`endif
  input  logic                I_IF_PC_WRITE,
  input  logic                I_IF_IFID_WRITE,
  input  logic                I_IF_BRANCH_TAKEN,
  input  logic [PC_WIDTH-1:0] I_IF_BRANCH_TARGET,
  input  logic                I_IF_JUMP,
  input  logic [PC_WIDTH-1:0] I_IF_JUMP_TARGET,
  input  logic                I_IF_IMEM_WE,
  input  logic [IMEM_AW-1:0]  I_IF_IMEM_ADDR,
  input  logic [31:0]         I_IF_IMEM_DATA,
  output logic [PC_WIDTH-1:0] O_IF_PC,
  output logic [31:0]         O_IF_ID_INSTR,
  output logic [PC_WIDTH-1:0] O_IF_ID_PC_PLUS4,
  output logic                O_IF_ID_VALID,
  output logic                O_IF_HALTED
);

  localparam logic [5:0] OPC_HALT = 6'b010101;

  logic [31:0]         imem [IMEM_DEPTH];

  logic [PC_WIDTH-1:0] pc;
  logic [31:0]         if_id_instr;
  logic [PC_WIDTH-1:0] if_id_pc_plus4;
  logic                if_id_valid;
  logic                halted;

  logic [IMEM_AW-1:0]  fetch_idx;
  logic [31:0]         fetch_instr;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic                redirect;
  logic                halt_pending;
  logic                freeze;
  logic                step_hold;

  // Word-indexed asynchronous fetch; upper PC bits wrap, byte offset ignored.
  assign fetch_idx    = pc[IMEM_AW+1:2];
  assign fetch_instr  = imem[fetch_idx];
  assign pc_plus4     = pc + PC_WIDTH'(4);

  assign redirect     = I_IF_BRANCH_TAKEN | I_IF_JUMP;
  // A HALT being flushed by an older redirect must not commit.
  assign halt_pending = if_id_valid & (if_id_instr[31:26] == OPC_HALT) & ~redirect;
  assign freeze       = halted | halt_pending;

`ifdef IF_DEBUG_STEP_EN
  assign step_hold = I_IF_STEP_MODE & ~I_IF_STEP;
`else
  assign step_hold = 1'b0;
`endif

  // Program counter: redirect beats halt and stall; otherwise advance by 4.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc <= RESET_PC;
    end else if (I_IF_BRANCH_TAKEN) begin
      pc <= I_IF_BRANCH_TARGET;
    end else if (I_IF_JUMP) begin
      pc <= I_IF_JUMP_TARGET;
    end else if (!freeze && !step_hold && I_IF_PC_WRITE) begin
      pc <= pc_plus4;
    end
  end

  // IF/ID register: flush on redirect, bubble on a held debug step, else load.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      if_id_instr    <= '0;
      if_id_pc_plus4 <= '0;
      if_id_valid    <= 1'b0;
    end else if (redirect) begin
      if_id_instr    <= '0;
      if_id_pc_plus4 <= '0;
      if_id_valid    <= 1'b0;
    end else if (!freeze && I_IF_IFID_WRITE) begin
      if (step_hold) begin
        if_id_instr    <= '0;
        if_id_pc_plus4 <= '0;
        if_id_valid    <= 1'b0;
      end else begin
        if_id_instr    <= fetch_instr;
        if_id_pc_plus4 <= pc_plus4;
        if_id_valid    <= 1'b1;
      end
    end
  end

  // Halt flag: sticky until reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      halted <= 1'b0;
    end else if (halt_pending) begin
      halted <= 1'b1;
    end
  end

  // Loader port; memory contents survive reset.
  always_ff @(posedge CLK) begin
    if (I_IF_IMEM_WE) begin
      imem[I_IF_IMEM_ADDR] <= I_IF_IMEM_DATA;
    end
  end

  assign O_IF_PC          = pc;
  assign O_IF_ID_INSTR    = if_id_instr;
  assign O_IF_ID_PC_PLUS4 = if_id_pc_plus4;
  assign O_IF_ID_VALID    = if_id_valid;
  assign O_IF_HALTED      = halted;

endmodule
